// File: rtl/psram_pkg.sv
// Shared PSRAM SPI definitions: opcodes and the responder state encoding.
// Latency: n/a (package only).
// Backpressure: n/a; both controller and responder import these names so opcodes agree.
package psram_pkg;

  // SPI command opcodes of the IPS6404L
  localparam logic [7:0] RESET_ENABLE = 8'h66;
  localparam logic [7:0] RESET        = 8'h99;
  localparam logic [7:0] READ         = 8'h03;
  localparam logic [7:0] WRITE        = 8'h02;
  localparam logic [7:0] READ_ID      = 8'h9F;

  // Length of the address phase that follows read, write and read-ID
  localparam int ADDR_PHASE_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_ID,
    ST_IGNORE
  } resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes sclk/ce_n/si into sysclk and produces one-cycle rise/fall/ce_rise strobes.
// Latency: ce_n_sync 2 sysclk after the pin; strobes and si_bit 3 sysclk after the pin edge.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
//
// Ports:
//   sysclk, reset      clock and asynchronous active-low reset
//   sclk, ce_n, si     raw SPI pins from the controller
//   ce_n_sync          synchronized chip enable (active low)
//   si_bit             synchronized si, aligned with the rise strobe
//   rise, fall         sclk edge strobes
//   ce_rise            ce_n deassertion strobe (end of transaction)
module spi_edge_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic sclk,
  input  logic ce_n,
  input  logic si,
  output logic ce_n_sync,
  output logic si_bit,
  output logic rise,
  output logic fall,
  output logic ce_rise
);

  logic [1:0] sclk_sync;
  logic [1:0] ce_sync;
  logic [1:0] si_sync;
  logic       sclk_prev;
  logic       ce_prev;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= 2'b00;
      ce_sync   <= 2'b11;   // chip deselected while in reset
      si_sync   <= 2'b00;
      sclk_prev <= 1'b0;
      ce_prev   <= 1'b1;
      rise      <= 1'b0;
      fall      <= 1'b0;
      ce_rise   <= 1'b0;
      si_bit    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      ce_sync   <= {ce_sync[0], ce_n};
      si_sync   <= {si_sync[0], si};
      sclk_prev <= sclk_sync[1];
      ce_prev   <= ce_sync[1];
      // Strobes are registered so that si_bit, sampled the same cycle, lines up with rise
      rise      <= sclk_sync[1] & ~sclk_prev;
      fall      <= ~sclk_sync[1] & sclk_prev;
      ce_rise   <= ce_sync[1] & ~ce_prev;
      si_bit    <= si_sync[1];
    end
  end

  assign ce_n_sync = ce_sync[1];

endmodule

// File: rtl/psram_responder.sv
// Device-side model of an IPS6404L PSRAM: decodes reset, read-ID, read and write over SPI mode 0.
// Latency: so updates 1 sysclk after the fall strobe; memory write 1 sysclk after the 8th rise of a byte.
// Backpressure: none; the controller owns sclk and must run it at most sysclk/4.
//
// Ports:
//   sysclk, reset         clock and asynchronous active-low reset
//   sclk, ce_n, si        SPI inputs from the controller
//   so, so_oe             serial data out and its output enable (read / read-ID data phase only)
//   last_cmd              last complete command byte
//   sw_reset_pulse        one-cycle pulse on a completed 0x66 -> 0x99 sequence
//   busy                  synchronized chip-enable active
module psram_responder
  import psram_pkg::*;
#(
  parameter int          ADDR_BITS = 10,
  parameter logic [7:0]  MFID      = 8'h0D,
  parameter logic [7:0]  KGD       = 8'h5D,
  parameter logic [47:0] EID       = 48'h0123_4567_89AB
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ce_n,
  input  logic       si,
  output logic       so,
  output logic       so_oe,
  output logic [7:0] last_cmd,
  output logic       sw_reset_pulse,
  output logic       busy
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [4:0]           LAST_BIT_OF_BYTE = 5'd7;
  localparam logic [4:0]           LAST_BIT_OF_ADDR = 5'(ADDR_PHASE_BITS - 1);

  logic ce_n_sync;
  logic si_bit;
  logic rise;
  logic fall;
  logic ce_rise;

  spi_edge_sync u_edge_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .sclk      (sclk),
    .ce_n      (ce_n),
    .si        (si),
    .ce_n_sync (ce_n_sync),
    .si_bit    (si_bit),
    .rise      (rise),
    .fall      (fall),
    .ce_rise   (ce_rise)
  );

  resp_state_t          state;
  resp_state_t          state_nxt;
  logic [4:0]           bit_cnt;
  logic [6:0]           shreg;       // bits received so far of the current byte
  logic [7:0]           cmd;
  logic [7:0]           tx_sr;       // outgoing byte, MSB shifted out first
  logic [ADDR_BITS-1:0] addr;
  logic [2:0]           id_idx;      // 0: MFID, 1: KGD, 2..7: EID bytes MSB first
  logic                 reset_armed;

  logic [7:0] mem [0:(2**ADDR_BITS)-1];

  logic [7:0]           rx_byte;
  logic [ADDR_BITS-1:0] addr_shift;
  logic                 byte_done;
  logic                 addr_done;
  logic                 mem_we;

  assign rx_byte    = {shreg, si_bit};
  // Shifting only the low bits keeps the 24-bit SPI address modulo the memory size
  assign addr_shift = {addr[ADDR_BITS-2:0], si_bit};
  assign byte_done  = rise && (bit_cnt == LAST_BIT_OF_BYTE);
  assign addr_done  = rise && (bit_cnt == LAST_BIT_OF_ADDR);
  assign busy       = ~ce_n_sync;

  function automatic logic [7:0] id_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = MFID;
    case (idx)
      3'd0: b = MFID;
      3'd1: b = KGD;
      3'd2: b = EID[47:40];
      3'd3: b = EID[39:32];
      3'd4: b = EID[31:24];
      3'd5: b = EID[23:16];
      3'd6: b = EID[15:8];
      3'd7: b = EID[7:0];
      default: b = MFID;
    endcase
    return b;
  endfunction

  // State register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; end of transaction and software reset override everything
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    if (ce_rise || sw_reset_pulse) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ce_n_sync) state_nxt = ST_CMD;
        end
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              READ, WRITE, READ_ID: state_nxt = ST_ADDR;
              default:              state_nxt = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (addr_done) begin
            case (cmd)
              READ:    state_nxt = ST_READ;
              WRITE:   state_nxt = ST_WRITE;
              default: state_nxt = ST_ID;
            endcase
          end
        end
        ST_WRITE: begin
          mem_we = byte_done;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      so             <= 1'b0;
      so_oe          <= 1'b0;
      last_cmd       <= 8'h00;
      sw_reset_pulse <= 1'b0;
      reset_armed    <= 1'b0;
      bit_cnt        <= 5'd0;
      shreg          <= 7'd0;
      cmd            <= 8'h00;
      tx_sr          <= 8'h00;
      addr           <= '0;
      id_idx         <= 3'd0;
    end else begin
      sw_reset_pulse <= 1'b0;
      so_oe          <= (state_nxt == ST_READ) || (state_nxt == ST_ID);
      if (ce_rise) begin
        // A bit whose rise coincides with ce_rise is dropped here
        bit_cnt <= 5'd0;
        so      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= 5'd0;
          end
          ST_CMD: begin
            if (rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (byte_done) begin
                bit_cnt     <= 5'd0;
                last_cmd    <= rx_byte;
                cmd         <= rx_byte;
                reset_armed <= (rx_byte == RESET_ENABLE);
                if ((rx_byte == RESET) && reset_armed) sw_reset_pulse <= 1'b1;
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              addr    <= addr_shift;
              bit_cnt <= bit_cnt + 5'd1;
              if (addr_done) begin
                bit_cnt <= 5'd0;
                if (cmd == READ) begin
                  tx_sr <= mem[addr_shift];
                end else if (cmd == READ_ID) begin
                  id_idx <= 3'd0;
                  tx_sr  <= id_byte(3'd0);
                end
              end
            end
          end
          ST_READ, ST_ID: begin
            if (fall) begin
              so    <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (byte_done) begin
                bit_cnt <= 5'd0;
                if (state == ST_READ) begin
                  addr  <= addr + ADDR_ONE;
                  tx_sr <= mem[addr + ADDR_ONE];
                end else begin
                  id_idx <= id_idx + 3'd1;
                  tx_sr  <= id_byte(id_idx + 3'd1);
                end
              end
            end
          end
          ST_WRITE: begin
            if (rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (byte_done) begin
                bit_cnt <= 5'd0;
                addr    <= addr + ADDR_ONE;
              end
            end
          end
          default: begin
            bit_cnt <= 5'd0;
          end
        endcase
      end
      if (sw_reset_pulse) reset_armed <= 1'b0;
    end
  end

  // Memory is deliberately not reset
  always_ff @(posedge sysclk) begin
    if (mem_we) mem[addr] <= rx_byte;
  end

endmodule

// File: tb/tb_psram_responder.sv
module tb_psram_responder;
  import psram_pkg::*;

  localparam int MSZ = 1024;
  localparam int H   = 5;   // sysclk cycles per sclk half period

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       sclk   = 1'b0;
  logic       ce_n   = 1'b1;
  logic       si     = 1'b0;
  logic       so;
  logic       so_oe;
  logic [7:0] last_cmd;
  logic       sw_reset_pulse;
  logic       busy;

  always #5 sysclk = ~sysclk;

  psram_responder dut (
    .sysclk         (sysclk),
    .reset          (reset),
    .sclk           (sclk),
    .ce_n           (ce_n),
    .si             (si),
    .so             (so),
    .so_oe          (so_oe),
    .last_cmd       (last_cmd),
    .sw_reset_pulse (sw_reset_pulse),
    .busy           (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int pulse_cnt = 0;
  int oe_cnt    = 0;
  always @(posedge sysclk) begin
    if (sw_reset_pulse) pulse_cnt++;
    if (so_oe) oe_cnt++;
  end

  // Reference model: byte memory with a written-flag per location, plus the ID sequence
  logic [7:0] mem_m [MSZ];
  bit         known [MSZ];
  logic [7:0] id_m  [8];

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One sclk period; so is sampled at the moment the controller raises sclk
  task automatic sclk_bit(input logic b, output logic r);
    si = b;
    wait_clk(H);
    r = so;
    sclk = 1'b1;
    wait_clk(H);
    sclk = 1'b0;
  endtask

  task automatic txn(input int rd_bytes, input int part_bits, input logic [7:0] part);
    logic       r;
    logic [7:0] b;
    rxq.delete();
    ce_n = 1'b0;
    wait_clk(H);
    foreach (txq[i]) begin
      b = txq[i];
      for (int k = 7; k >= 0; k--) sclk_bit(b[k], r);
    end
    for (int k = 7; k >= 8 - part_bits; k--) sclk_bit(part[k], r);
    for (int j = 0; j < rd_bytes; j++) begin
      b = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        sclk_bit(1'b0, r);
        b[k] = r;
      end
      rxq.push_back(b);
    end
    wait_clk(H);
    ce_n = 1'b1;
    wait_clk(4 * H);
  endtask

  task automatic mk(input logic [7:0] c, input logic [23:0] a);
    txq.delete();
    txq.push_back(c);
    txq.push_back(a[23:16]);
    txq.push_back(a[15:8]);
    txq.push_back(a[7:0]);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] d[$], input int pbits);
    mk(WRITE, a);
    foreach (d[i]) txq.push_back(d[i]);
    txn(0, pbits, 8'($urandom));
    foreach (d[i]) begin
      mem_m[(int'(a) + i) % MSZ] = d[i];
      known[(int'(a) + i) % MSZ] = 1'b1;
    end
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int n);
    int o0;
    o0 = oe_cnt;
    mk(READ, a);
    txn(n, 0, 8'h00);
    chk({tag, "_oe"}, 32'(oe_cnt > o0), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (known[(int'(a) + i) % MSZ])
        chk($sformatf("%s_b%0d", tag, i), 32'(rxq[i]), 32'(mem_m[(int'(a) + i) % MSZ]));
    end
  endtask

  task automatic do_id(input string tag, input int n);
    mk(READ_ID, 24'($urandom));
    txn(n, 0, 8'h00);
    for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", tag, i), 32'(rxq[i]), 32'(id_m[i % 8]));
  endtask

  task automatic cmd_only(input logic [7:0] c);
    txq.delete();
    txq.push_back(c);
    txn(0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0]  d[$];
    logic [23:0] a;
    logic [7:0]  op;
    int          p0;
    int          o0;
    logic        r;
    int          kind;
    int          last_wa;

    id_m = '{8'h0D, 8'h5D, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    foreach (known[i]) known[i] = 1'b0;

    // Reset state
    wait_clk(3);
    chk("rst_so", 32'(so), 32'd0);
    chk("rst_so_oe", 32'(so_oe), 32'd0);
    chk("rst_last_cmd", 32'(last_cmd), 32'h00);
    chk("rst_pulse", 32'(sw_reset_pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_clk(4);

    // Reset-enable followed by reset
    p0 = pulse_cnt;
    cmd_only(RESET_ENABLE);
    cmd_only(RESET);
    chk("swrst_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("swrst_last_cmd", 32'(last_cmd), 32'h99);

    // 0x99 alone, and 0x99 not immediately after 0x66
    p0 = pulse_cnt;
    cmd_only(RESET);
    chk("lone99_pulse", 32'(pulse_cnt - p0), 32'd0);
    cmd_only(RESET_ENABLE);
    cmd_only(8'h5A);
    cmd_only(RESET);
    chk("gap99_pulse", 32'(pulse_cnt - p0), 32'd0);

    // Unknown opcode followed by more clocks: never drives so
    o0 = oe_cnt;
    p0 = pulse_cnt;
    mk(8'h5A, 24'h000000);
    txn(2, 0, 8'h00);
    chk("unk_oe", 32'(oe_cnt - o0), 32'd0);
    chk("unk_pulse", 32'(pulse_cnt - p0), 32'd0);
    chk("unk_last_cmd", 32'(last_cmd), 32'h5A);

    // Read-ID at address FFFFFF
    mk(READ_ID, 24'hFFFFFF);
    txn(8, 0, 8'h00);
    for (int i = 0; i < 8; i++) chk($sformatf("id_b%0d", i), 32'(rxq[i]), 32'(id_m[i]));

    // Write / read back
    d = '{8'h12, 8'hAA, 8'h00, 8'h18, 8'hDD};
    do_write(24'h000000, d, 0);
    do_read("rd0", 24'h000000, 5);
    d = '{8'hBA, 8'hAA};
    do_write(24'h0000FF, d, 0);
    do_read("rdff", 24'h0000FF, 2);

    // Wrap at the top of memory, for both write and read
    d = '{8'h11, 8'h22};
    do_write(24'h0003FF, d, 0);
    do_read("wrap", 24'h0003FF, 2);
    chk("wrap_top", 32'(mem_m[1023]), 32'h11);

    // Write aborted after 5 bits leaves the byte alone
    d.delete();
    do_write(24'h000001, d, 5);
    do_read("part", 24'h000001, 1);
    chk("part_val", 32'(rxq[0]), 32'hAA);

    // Randomized mix
    last_wa = 0;
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1: begin
          a = 24'($urandom);
          if ($urandom_range(0, 3) == 0) a[9:0] = 10'h3FE;
          d.delete();
          for (int i = 0; i < int'($urandom_range(1, 4)); i++) d.push_back(8'($urandom));
          do_write(a, d, int'($urandom_range(0, 7)));
          last_wa = int'(a[9:0]);
        end
        2: begin
          a = {14'($urandom), 10'(last_wa)};
          do_read($sformatf("rr%0d", t), a, int'($urandom_range(1, 5)));
        end
        3: do_id($sformatf("rid%0d", t), int'($urandom_range(1, 10)));
        default: begin
          op = 8'($urandom);
          if (op == READ || op == WRITE || op == READ_ID || op == RESET_ENABLE || op == RESET) op = 8'h00;
          o0 = oe_cnt;
          p0 = pulse_cnt;
          mk(op, 24'($urandom));
          txn(1, 0, 8'h00);
          chk($sformatf("rop%0d_oe", t), 32'(oe_cnt - o0), 32'd0);
          chk($sformatf("rop%0d_pulse", t), 32'(pulse_cnt - p0), 32'd0);
        end
      endcase
    end

    // Reset pulled low in the middle of a read
    mk(READ, 24'h000000);
    ce_n = 1'b0;
    wait_clk(H);
    foreach (txq[i]) begin
      op = txq[i];
      for (int k = 7; k >= 0; k--) sclk_bit(op[k], r);
    end
    for (int k = 0; k < 3; k++) sclk_bit(1'b0, r);
    chk("midrd_oe_before", 32'(so_oe), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrd_oe_reset", 32'(so_oe), 32'd0);
    chk("midrd_busy_reset", 32'(busy), 32'd0);
    ce_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(4);
    do_id("post_rst_id", 3);
    do_read("post_rst_rd", 24'h000000, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
